// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the serial-in / parallel-out deserializer.
//   deser_state_e   : FSM encoding (IDLE = no partial word, SHIFT = partial word)
//   DESER_WIDTH     : default parallel word width
//   DESER_MSB_FIRST : default bit order (1 = first serial bit lands in the MSB)
package sipo_deserializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } deser_state_e;

  localparam int DESER_WIDTH     = 8;
  localparam int DESER_MSB_FIRST = 1;

endpackage

// File: rtl/sipo_shifter.sv
// Shift register plus bit counter for the deserializer.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset (clears counter and shift register)
//   capture : take sin into the shift register this edge
//   sin     : serial data bit
//   word    : the word as it would stand after shifting sin in now; it is the
//             complete word whenever done is high
//   done    : this capture is the WIDTH-th bit of a word
module sipo_shifter
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH,
  parameter int MSB_FIRST = DESER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic             sin,
  output logic [WIDTH-1:0] word,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic             last;

  // MSB-first words shift left so the first bit ends up at WIDTH-1;
  // LSB-first words shift right so the first bit ends up at bit 0.
  always_comb begin
    if (MSB_FIRST != 0) begin
      shifted = {sreg[WIDTH-2:0], sin};
    end else begin
      shifted = {sin, sreg[WIDTH-1:1]};
    end
  end

  assign last = (count == CW'(WIDTH - 1));
  assign done = capture && last;
  assign word = shifted;

  // Counter wraps straight to 0 on the last bit so the next word may start
  // on the very next valid cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      sreg  <= '0;
    end else if (capture) begin
      sreg  <= shifted;
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with a single-entry output register.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   sin_valid : sin carries a valid bit this cycle
//   sin       : serial data bit
//   out_ready : downstream accepts out_data this cycle
//   ovr_clr   : synchronous clear of the overrun flag
//   out_data  : assembled parallel word (registered)
//   out_valid : out_data holds an unaccepted word
//   busy      : a partial word is in progress
//   overrun   : sticky, a completed word was dropped
//   dbg_state : current FSM state
//
// Output handshake: a word transfers on a rising edge where out_valid=1 and
// out_ready=1. out_data is held stable while out_valid=1 and the word has not
// transferred; out_ready has no effect while out_valid=0. A word that
// completes while the register is full and not transferring is dropped and
// raises overrun; one completing on a transfer edge replaces the old word.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH     = DESER_WIDTH,
  parameter int MSB_FIRST = DESER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output deser_state_e     dbg_state
);

  logic [WIDTH-1:0] word;
  logic             word_done;

  deser_state_e     state_q;
  deser_state_e     state_d;

  logic [WIDTH-1:0] data_d;
  logic             valid_d;
  logic             ovr_d;
  logic             accept;
  logic             drop;

  sipo_shifter #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .capture(sin_valid),
    .sin    (sin),
    .word   (word),
    .done   (word_done)
  );

  // FSM: WIDTH >= 2, so the first bit of a word can never also be its last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sin_valid) state_d = SHIFT;
      SHIFT:   if (word_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign dbg_state = state_q;

  // Output register, handshake and overrun.
  always_comb begin
    data_d  = out_data;
    valid_d = out_valid;
    ovr_d   = overrun;
    accept  = out_valid && out_ready;
    drop    = word_done && out_valid && !out_ready;
    if (word_done && !drop) begin
      data_d  = word;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
    // A drop on the same edge as a clear leaves the flag set.
    if (drop) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_data  <= data_d;
      out_valid <= valid_d;
      overrun   <= ovr_d;
    end
  end

endmodule
